// File: rtl/seg7_pkg.sv
// Shared segment codes and the BCD/hex to 7-segment decode function.
// Segment bit order is [0]=a .. [6]=g; patterns are active-high (1 = lit).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code, input logic hex_en);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    // Decimal-only builds show nothing for codes 10-15.
    if (!hex_en && code > 4'd9) seg = SEG_BLANK;
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational digit decoder with a forced-blank input, active-high segments.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int unsigned HEX_EN = 1
) (
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg7_decode(code, HEX_EN != 0);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver: shadow register, prescaler, digit index,
// leading-zero mask, digit mux and polarity-adjusted output registers.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned HEX_EN         = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    slot_tick
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned PreW   = $clog2(SCAN_DIV);
  localparam logic        SegInv = (SEG_ACTIVE_LOW != 0);
  localparam logic        AnInv  = (AN_ACTIVE_LOW != 0);

  logic [4*NUM_DIGITS-1:0] shadow_digits_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q;
  logic                    shadow_lz_q;
  logic [PreW-1:0]         presc_q;
  logic [IdxW-1:0]         idx_q;

  logic                    last_count;
  logic                    last_idx;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_hi;
  logic [6:0]              seg_hi;

  assign last_count = (presc_q == PreW'(SCAN_DIV - 1));
  assign last_idx   = (idx_q == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    cur_code   = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    an_hi      = '0;
    // Walk from the most significant digit down; blanking stops at the first non-zero.
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (shadow_digits_q[4*i +: 4] == 4'd0);
      lz_mask[i] = shadow_lz_q && upper_zero && (i != 0);
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_code  = shadow_digits_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = lz_mask[i];
        // Slot count 0 is dead time so the previous digit's segments never ghost.
        an_hi[i]  = en && (presc_q != '0);
      end
    end
  end

  seg7_hex_decode #(
    .HEX_EN(HEX_EN)
  ) u_decode (
    .code (cur_code),
    .blank(cur_blank),
    .seg  (seg_hi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      shadow_lz_q     <= 1'b0;
      presc_q         <= '0;
      idx_q           <= '0;
      seg_out         <= {7{SegInv}};
      dp_out          <= SegInv;
      an_out          <= {NUM_DIGITS{AnInv}};
      slot_tick       <= 1'b0;
    end else begin
      if (load) begin
        shadow_digits_q <= digits_in;
        shadow_dp_q     <= dp_in;
        shadow_lz_q     <= lz_blank;
      end
      if (en) begin
        if (last_count) begin
          presc_q <= '0;
          idx_q   <= last_idx ? '0 : idx_q + IdxW'(1);
        end else begin
          presc_q <= presc_q + PreW'(1);
        end
      end
      seg_out   <= seg_hi ^ {7{SegInv}};
      dp_out    <= cur_dp ^ SegInv;
      an_out    <= an_hi ^ {NUM_DIGITS{AnInv}};
      slot_tick <= en && last_count;
    end
  end

endmodule
